// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// sub_in exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_in;
`endif
    logic             busy;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub_in,
`endif
        output start_valid, a_in, b_in, cin_in, done_ready,
        input  start_ready, busy, done_valid, sum_out, cout_out
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub_in,
`endif
        input  start_valid, a_in, b_in, cin_in, done_ready,
        output start_ready, busy, done_valid, sum_out, cout_out
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder stepped LSB..MSB, carry held in a flop.
// Optional subtract mode enabled by macro SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_done_valid;
    logic             r_busy;
    logic             r_start_ready;
`ifdef SERIAL_ADDER_SUB_EN
    logic             r_sub;
`endif

    logic             w_b_bit;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_bit = r_b[0] ^ r_sub;
`else
    assign w_b_bit = r_b[0];
`endif
    assign w_s    = r_a[0] ^ w_b_bit ^ r_c;
    assign w_co   = (r_a[0] & w_b_bit) | (r_c & (r_a[0] ^ w_b_bit));
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res1
            assign w_res_next = w_s;
        end else begin : g_resn
            assign w_res_next = {w_s, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_res         <= '0;
            r_c           <= 1'b0;
            r_cnt         <= '0;
            r_sum         <= '0;
            r_cout        <= 1'b0;
            r_done_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub         <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        r_a           <= bus.a_in;
                        r_b           <= bus.b_in;
                        r_res         <= '0;
                        r_cnt         <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        r_sub         <= bus.sub_in;
                        r_c           <= bus.sub_in ? 1'b1 : bus.cin_in;
`else
                        r_c           <= bus.cin_in;
`endif
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_co;
                    r_res <= w_res_next;
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_sum        <= w_res_next;
                        r_cout       <= w_co;
                        r_done_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.done_ready) begin
                        r_done_valid  <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.start_ready = r_start_ready;
    assign bus.busy        = r_busy;
    assign bus.done_valid  = r_done_valid;
    assign bus.sum_out     = r_sum;
    assign bus.cout_out    = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 vector table plus handshake,
// backpressure and reset sequences, and a WIDTH=1 truth-table sweep.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) if1 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[10];
    int   nvec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for done_valid on the WIDTH=8 DUT; returns edges counted.
    task automatic wait_done8(output int n, output logic sr_high);
        n = 0;
        sr_high = 1'b0;
        while (!if8.done_valid && n < 40) begin
            if (if8.start_ready) sr_high = 1'b1;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic op8(input string name, input vec_t v);
        int   n;
        logic sr_high;
        @(negedge clk);
        chk({name, "_ready_idle"}, 32'(if8.start_ready), 32'd1);
        if8.start_valid = 1'b1;
        if8.a_in = v.a;
        if8.b_in = v.b;
        if8.cin_in = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
        if8.sub_in = v.sub;
`endif
        @(posedge clk);
        @(negedge clk);
        if8.start_valid = 1'b0;
        wait_done8(n, sr_high);
        chk({name, "_latency"}, 32'(n), 32'd8);
        chk({name, "_ready_low_run"}, 32'(sr_high), 32'd0);
        chk({name, "_sum"}, 32'(if8.sum_out), 32'(v.exp_sum));
        chk({name, "_cout"}, 32'(if8.cout_out), 32'(v.exp_cout));
        if8.done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.done_ready = 1'b0;
        chk({name, "_dv_clear"}, 32'(if8.done_valid), 32'd0);
        chk({name, "_ready_back"}, 32'(if8.start_ready), 32'd1);
    endtask

    task automatic op1(input logic a, input logic b, input logic c);
        int n;
        logic [1:0] exp;
        exp = 2'(a) + 2'(b) + 2'(c);
        @(negedge clk);
        if1.start_valid = 1'b1;
        if1.a_in = a;
        if1.b_in = b;
        if1.cin_in = c;
        @(posedge clk);
        @(negedge clk);
        if1.start_valid = 1'b0;
        n = 0;
        while (!if1.done_valid && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk($sformatf("w1_%0d%0d%0d_latency", a, b, c), 32'(n), 32'd1);
        chk($sformatf("w1_%0d%0d%0d_result", a, b, c), 32'({if1.cout_out, if1.sum_out}), 32'(exp));
        if1.done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if1.done_ready = 1'b0;
    endtask

    initial begin
        int   n;
        logic sr_high;
        logic [7:0] held;

        if8.start_valid = 1'b0; if8.a_in = '0; if8.b_in = '0; if8.cin_in = 1'b0; if8.done_ready = 1'b0;
        if1.start_valid = 1'b0; if1.a_in = '0; if1.b_in = '0; if1.cin_in = 1'b0; if1.done_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        if8.sub_in = 1'b0;
        if1.sub_in = 1'b0;
`endif

        nvec = 0;
        vecs[nvec++] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
        vecs[nvec++] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[nvec++] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[nvec++] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[nvec++] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
        vecs[nvec++] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
        vecs[nvec++] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
        vecs[nvec++] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0};
        vecs[nvec++] = '{8'h01, 8'h01, 1'b1, 1'b0, 8'h03, 1'b0};
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sum", 32'(if8.sum_out), 32'd0);
        chk("rst_cout", 32'(if8.cout_out), 32'd0);
        chk("rst_dv", 32'(if8.done_valid), 32'd0);
        chk("rst_busy", 32'(if8.busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(if8.start_ready), 32'd1);

        for (int i = 0; i < nvec; i++) op8($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back: second start held high through the first operation.
        @(negedge clk);
        if8.start_valid = 1'b1; if8.a_in = 8'hFF; if8.b_in = 8'h01; if8.cin_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.a_in = 8'hFF; if8.b_in = 8'hFF; if8.cin_in = 1'b1;
        wait_done8(n, sr_high);
        chk("b2b1_latency", 32'(n), 32'd8);
        chk("b2b1_sum", 32'({if8.cout_out, if8.sum_out}), 32'h100);
        if8.done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.done_ready = 1'b0;
        chk("b2b_idle_busy", 32'(if8.busy), 32'd0);
        chk("b2b_idle_ready", 32'(if8.start_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if8.start_valid = 1'b0;
        chk("b2b2_accepted", 32'({if8.busy, if8.start_ready}), 32'b10);
        wait_done8(n, sr_high);
        chk("b2b2_latency", 32'(n), 32'd8);
        chk("b2b2_sum", 32'({if8.cout_out, if8.sum_out}), 32'h1FF);
        if8.done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.done_ready = 1'b0;

        // Backpressure: result held while a new start is offered.
        if8.start_valid = 1'b1; if8.a_in = 8'h5A; if8.b_in = 8'h3C; if8.cin_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.a_in = 8'h11; if8.b_in = 8'h22;
        wait_done8(n, sr_high);
        held = if8.sum_out;
        chk("bp_first", 32'(held), 32'h96);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k),
                32'({if8.done_valid, if8.start_ready, if8.cout_out, if8.sum_out}),
                32'({1'b1, 1'b0, 1'b0, 8'h96}));
        end
        if8.done_ready = 1'b1;
        if8.start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.done_ready = 1'b0;
        chk("bp_release", 32'({if8.done_valid, if8.start_ready, if8.busy}), 32'b010);

        // Asynchronous reset three bits into a run.
        if8.start_valid = 1'b1; if8.a_in = 8'hFF; if8.b_in = 8'h01; if8.cin_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if8.start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs",
            32'({if8.sum_out, if8.cout_out, if8.done_valid, if8.busy, if8.start_ready}),
            32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        op8("after_rst", '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0});

        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            op1(abc[2], abc[1], abc[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
